// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush,
// data-memory wait and MUL/DIV occupancy into register enables, bubbles and flushes.
module pipeline_stall_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic [4:0]             rd_ex,
    input  logic                   mem_read_ex,
    input  logic                   branch_taken_ex,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    input  logic                   mdu_start_ex,
    input  logic                   mdu_done,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   ex_mem_hold,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_timeout_err,
    output logic [1:0]             state_dbg
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic                   err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   freeze;
    logic                   load_use;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_id == rd_ex) || (rs2_id == rd_ex));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        err_d        = err_q;
        freeze       = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_hold  = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        freeze  = 1'b1;
                        state_d = MEM_WAIT;
                        wcnt_d  = '0;
                    end else if (mdu_start_ex && !mdu_done) begin
                        freeze  = 1'b1;
                        state_d = MDU_WAIT;
                    end else if (branch_taken_ex) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Timeout releases the pipeline just like a completed access.
                    if (dmem_ready) begin
                        state_d = RUN;
                    end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        freeze = 1'b1;
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_d = RUN;
                    end else begin
                        freeze = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end

        stall_d = pc_write ? stall_q : sat_inc(stall_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign mem_timeout_err = err_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios followed by random traffic,
// all compared cycle by cycle against a rule-level reference model.
module tb_pipeline_stall_ctrl;

    localparam int SCW = 3;
    localparam int MTO = 4;
    localparam int SAT = (1 << SCW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4:0]     rs1_id, rs2_id, rd_ex;
    logic           mem_read_ex, branch_taken_ex, dmem_req, dmem_ready;
    logic           mdu_start_ex, mdu_done;
    logic           pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold;
    logic [SCW-1:0] stall_cycles;
    logic           mem_timeout_err;
    logic [1:0]     state_dbg;

    pipeline_stall_ctrl #(.STALL_CNT_W(SCW), .MEM_TIMEOUT(MTO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .ex_mem_hold(ex_mem_hold), .stall_cycles(stall_cycles),
        .mem_timeout_err(mem_timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = waiting on MUL/DIV.
    int m_mode = 0, m_wait = 0, m_stalls = 0, m_err = 0;
    int n_mode, n_wait, n_err;
    bit e_pc, e_ifid, e_bub, e_flush, e_hold;

    task automatic model_eval();
        bit hazard;
        bit frz;
        frz = 0;
        n_mode = m_mode; n_wait = m_wait; n_err = m_err;
        e_pc = 1; e_ifid = 1; e_bub = 0; e_flush = 0; e_hold = 0;
        hazard = mem_read_ex && rd_ex != 0 && (rs1_id == rd_ex || rs2_id == rd_ex);
        if (rst_n) begin
            if (m_mode == 0) begin
                if (dmem_req && !dmem_ready) begin frz = 1; n_mode = 1; n_wait = 0; end
                else if (mdu_start_ex && !mdu_done) begin frz = 1; n_mode = 2; end
                else if (branch_taken_ex) begin e_flush = 1; e_bub = 1; end
                else if (hazard) begin e_pc = 0; e_ifid = 0; e_bub = 1; end
            end else if (m_mode == 1) begin
                if (dmem_ready) n_mode = 0;
                else if (m_wait + 1 == MTO) begin n_mode = 0; n_err = 1; end
                else begin frz = 1; n_wait = m_wait + 1; end
            end else begin
                if (mdu_done) n_mode = 0;
                else frz = 1;
            end
        end
        if (frz) begin e_pc = 0; e_ifid = 0; e_hold = 1; end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_mode = 0; m_wait = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (!e_pc && m_stalls < SAT) m_stalls++;
            m_mode = n_mode; m_wait = n_wait; m_err = n_err;
        end
    endtask

    int n_pc0, n_hold0;
    bit o_pc, o_bub, o_flush;
    int st_hist[$];

    task automatic step();
        @(negedge clk);
        model_eval();
        check("pc_write",     32'(pc_write),        32'(e_pc));
        check("if_id_write",  32'(if_id_write),     32'(e_ifid));
        check("id_ex_bubble", 32'(id_ex_bubble),    32'(e_bub));
        check("if_id_flush",  32'(if_id_flush),     32'(e_flush));
        check("ex_mem_hold",  32'(ex_mem_hold),     32'(e_hold));
        check("stall_cycles", 32'(stall_cycles),    32'(m_stalls));
        check("timeout_err",  32'(mem_timeout_err), 32'(m_err));
        check("state_dbg",    32'(state_dbg),       32'(m_mode));
        if (!pc_write) n_pc0++;
        if (ex_mem_hold) n_hold0++;
        o_pc = pc_write; o_bub = id_ex_bubble; o_flush = if_id_flush;
        st_hist.push_back(int'(state_dbg));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        rs1_id = 0; rs2_id = 0; rd_ex = 0; mem_read_ex = 0; branch_taken_ex = 0;
        dmem_req = 0; dmem_ready = 0; mdu_start_ex = 0; mdu_done = 0;
    endtask

    initial begin
        int s0;
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;

        // Reset held while memory is stalling
        dmem_req = 1; dmem_ready = 0;
        step(); step();
        check("rst_pc_write", 32'(o_pc), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_stalls", 32'(stall_cycles), 32'd0);
        check("rst_err", 32'(mem_timeout_err), 32'd0);
        rst_n = 1; idle_inputs();
        step();

        // Load-use: single stall cycle
        n_pc0 = 0;
        mem_read_ex = 1; rd_ex = 5; rs1_id = 1; rs2_id = 5;
        step();
        check("lu_bubble", 32'(o_bub), 32'd1);
        mem_read_ex = 0;
        step(); step();
        check("lu_stall_count", 32'(n_pc0), 32'd1);
        check("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // Load from x0 never stalls
        n_pc0 = 0;
        mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        step(); step();
        check("x0_no_stall", 32'(n_pc0), 32'd0);
        idle_inputs();

        // Branch wins over simultaneous load-use
        mem_read_ex = 1; rd_ex = 5; rs2_id = 5; branch_taken_ex = 1;
        step();
        check("br_flush", 32'(o_flush), 32'd1);
        check("br_bubble", 32'(o_bub), 32'd1);
        check("br_pc_write", 32'(o_pc), 32'd1);
        idle_inputs();
        step();

        // Memory wait: three frozen cycles then advance
        s0 = int'(stall_cycles);
        n_pc0 = 0; st_hist.delete();
        dmem_req = 1; dmem_ready = 0;
        step(); step(); step();
        dmem_ready = 1;
        step();
        check("mw_pc_adv", 32'(o_pc), 32'd1);
        idle_inputs();
        check("mw_freeze_cycles", 32'(n_pc0), 32'd3);
        check("mw_state_seq", {8'(st_hist[0]), 8'(st_hist[1]), 8'(st_hist[2]), 8'(st_hist[3])},
              32'h00010101);
        check("mw_state_after", 32'(state_dbg), 32'd0);
        check("mw_stalls", 32'(stall_cycles), 32'(s0 + 3));

        // Timeout: four frozen cycles, release, sticky error, counter saturates
        n_pc0 = 0;
        dmem_req = 1; dmem_ready = 0;
        step(); step(); step(); step(); step();
        check("to_release", 32'(o_pc), 32'd1);
        dmem_req = 0;
        check("to_freeze_cycles", 32'(n_pc0), 32'd4);
        check("to_err", 32'(mem_timeout_err), 32'd1);
        check("to_state", 32'(state_dbg), 32'd0);
        check("sat_stalls", 32'(stall_cycles), 32'(SAT));

        // MUL/DIV occupancy: done arrives five cycles after start
        n_hold0 = 0; st_hist.delete();
        mdu_start_ex = 1; mdu_done = 0;
        step(); step(); step(); step(); step();
        mdu_done = 1;
        step();
        idle_inputs();
        check("mdu_hold_cycles", 32'(n_hold0), 32'd5);
        check("mdu_state_wait", 32'(st_hist[3]), 32'd2);
        check("mdu_state_after", 32'(state_dbg), 32'd0);
        check("mdu_err_sticky", 32'(mem_timeout_err), 32'd1);
        check("mdu_sat_hold", 32'(stall_cycles), 32'(SAT));

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n           = ($urandom_range(0, 99) >= 3);
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rd_ex           = 5'($urandom_range(0, 3));
            mem_read_ex     = ($urandom_range(0, 2) == 0);
            branch_taken_ex = ($urandom_range(0, 5) == 0);
            dmem_req        = ($urandom_range(0, 4) == 0);
            dmem_ready      = ($urandom_range(0, 3) == 0);
            mdu_start_ex    = ($urandom_range(0, 7) == 0);
            mdu_done        = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
